// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch-path configuration and types for the instruction fetch responder.
package inst_fetch_resp_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] BOOT_IT_ADDR = 32'h0000_0000;
    localparam int          IT_RAM_DEPTH = 4096;
    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        TURE         = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam int          IT_ADDR_W    = $clog2(IT_RAM_DEPTH / 4);

    typedef struct packed {
        logic [31:0] inst;
        logic        valid;
        logic        fault;
    } fetch_out_t;

endpackage

// File: rtl/inst_fetch_resp.sv
// Fetch responder: drives the instruction RAM from the PC and presents the
// returned instruction to decode, tracking the PC register's stall/redirect rules.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int               XLEN      = inst_fetch_resp_pkg::XLEN,
    parameter logic [XLEN-1:0]  BOOT_ADDR = inst_fetch_resp_pkg::BOOT_IT_ADDR,
    parameter int               IT_DEPTH  = inst_fetch_resp_pkg::IT_RAM_DEPTH,
    parameter logic [31:0]      NOP_INST  = inst_fetch_resp_pkg::NOP_INST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [XLEN-1:0]               pc_addr,
    input  logic                          pc_en,
    input  logic                          load_hazard,
    input  logic                          pc_write_flag,
    input  logic [XLEN-1:0]               pc_write_addr,
    output logic                          ram_en,
    output logic [$clog2(IT_DEPTH/4)-1:0] ram_addr,
    input  logic [31:0]                   ram_rdata,
    output logic [31:0]                   id_inst,
    output logic [XLEN-1:0]               id_pc,
    output logic                          id_valid,
    output logic                          id_fault
);

    localparam int         AW       = $clog2(IT_DEPTH / 4);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    // One bit wider than XLEN so the end-of-RAM bound cannot wrap.
    localparam logic [XLEN:0] LIMIT = {1'b0, BOOT_ADDR} + (XLEN+1)'(IT_DEPTH);

    logic [1:0]      state;
    logic [XLEN-1:0] pc_q;
    logic            en_q;
    logic            flush_q;
    logic            fault_q;
    fetch_out_t      hold;
    fetch_out_t      run_out;
    fetch_out_t      cur_out;
    logic            bad;
    logic            redir_ok;
    logic [XLEN-1:0] offset;

    always_comb begin
        bad      = (pc_addr[1:0] != 2'b00) || (pc_addr < BOOT_ADDR) ||
                   ({1'b0, pc_addr} >= LIMIT);
        redir_ok = pc_write_flag && !load_hazard && ({1'b0, pc_write_addr} < LIMIT);
        offset   = pc_addr - BOOT_ADDR;
    end

    assign ram_en   = pc_en && !load_hazard && !bad;
    assign ram_addr = AW'(offset >> 2);

    always_comb begin
        run_out.inst  = (flush_q || fault_q || !en_q) ? NOP_INST : ram_rdata;
        run_out.valid = en_q && !flush_q;
        run_out.fault = fault_q && !flush_q;
    end

    always_comb begin
        cur_out = '{inst: NOP_INST, valid: 1'b0, fault: 1'b0};
        case (state)
            ST_BOOT:  cur_out = '{inst: NOP_INST, valid: 1'b0, fault: 1'b0};
            ST_RUN:   cur_out = run_out;
            ST_STALL: cur_out = hold;
            default:  cur_out = '{inst: NOP_INST, valid: 1'b0, fault: 1'b0};
        endcase
    end

    assign id_inst  = cur_out.inst;
    assign id_valid = cur_out.valid;
    assign id_fault = cur_out.fault;
    assign id_pc    = pc_q;

    // A hazard freezes the fetch pipeline; hold is captured only on stall entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc_q    <= BOOT_ADDR;
            en_q    <= 1'b0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
            hold    <= '{inst: NOP_INST, valid: 1'b0, fault: 1'b0};
        end else if (load_hazard) begin
            state <= ST_STALL;
            if (state != ST_STALL) begin
                hold <= cur_out;
            end else begin
                hold <= hold;
            end
        end else begin
            state   <= ST_RUN;
            pc_q    <= pc_addr;
            en_q    <= pc_en;
            fault_q <= bad && pc_en;
            flush_q <= redir_ok;
            hold    <= hold;
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Table-driven bench for inst_fetch_resp with a synchronous instruction RAM model.
module tb_inst_fetch_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = 32'h0;
    logic        pc_en = 1'b0;
    logic        load_hazard = 1'b0;
    logic        pc_write_flag = 1'b0;
    logic [31:0] pc_write_addr = 32'h0;
    logic        ram_en;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_fault;

    logic [31:0] mem [0:1023];

    int total = 0;
    int bad_cnt = 0;
    int row = 0;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        lh;
        logic        wf;
        logic [31:0] wa;
        logic        x_ram_en;
        logic [31:0] x_inst;
        logic [31:0] x_pc;
        logic        x_valid;
        logic        x_fault;
    } vec_t;

    vec_t vecs[$];

    inst_fetch_resp dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_en(pc_en),
        .load_hazard(load_hazard), .pc_write_flag(pc_write_flag),
        .pc_write_addr(pc_write_addr), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .id_inst(id_inst), .id_pc(id_pc),
        .id_valid(id_valid), .id_fault(id_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    function automatic logic [31:0] m(input int i);
        if (i == 0) return 32'h0050_0093;
        if (i == 1) return 32'h00A0_0113;
        return 32'hA000_0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic en, input logic lh,
                       input logic wf, input logic [31:0] wa, input logic xre,
                       input logic [31:0] xinst, input logic [31:0] xpc,
                       input logic xv, input logic xf);
        vec_t v;
        v.pc = pc; v.en = en; v.lh = lh; v.wf = wf; v.wa = wa;
        v.x_ram_en = xre; v.x_inst = xinst; v.x_pc = xpc;
        v.x_valid = xv; v.x_fault = xf;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] want_idx;
        for (int i = 0; i < 1024; i++) mem[i] = m(i);

        //   pc        en    lh    wf    wa          ram_en inst      id_pc     valid fault
        add(32'h000, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, NOP,      32'h000,  1'b0, 1'b0);
        add(32'h004, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, m(0),     32'h000,  1'b1, 1'b0);
        add(32'h008, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, m(1),     32'h004,  1'b1, 1'b0);
        add(32'h00C, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, m(2),     32'h008,  1'b1, 1'b0);
        add(32'h00C, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, m(2),     32'h008,  1'b1, 1'b0);
        add(32'h00C, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, m(2),     32'h008,  1'b1, 1'b0);
        add(32'h010, 1'b1, 1'b0, 1'b1, 32'h40,    1'b1, m(3),     32'h00C,  1'b1, 1'b0);
        add(32'h040, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, NOP,      32'h010,  1'b0, 1'b0);
        add(32'h044, 1'b1, 1'b0, 1'b1, 32'h80,    1'b1, m(16),    32'h040,  1'b1, 1'b0);
        add(32'h080, 1'b1, 1'b0, 1'b1, 32'h100,   1'b1, NOP,      32'h044,  1'b0, 1'b0);
        add(32'h100, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, NOP,      32'h080,  1'b0, 1'b0);
        add(32'h104, 1'b1, 1'b0, 1'b1, 32'h1000,  1'b1, m(64),    32'h100,  1'b1, 1'b0);
        add(32'h108, 1'b1, 1'b1, 1'b1, 32'h20,    1'b0, m(65),    32'h104,  1'b1, 1'b0);
        add(32'h108, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, m(65),    32'h104,  1'b1, 1'b0);
        add(32'h10C, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, m(66),    32'h108,  1'b1, 1'b0);
        add(32'h10C, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, NOP,      32'h10C,  1'b0, 1'b0);
        add(32'h006, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, m(67),    32'h10C,  1'b1, 1'b0);
        add(32'h1000,1'b1, 1'b0, 1'b0, 32'h0,     1'b0, NOP,      32'h006,  1'b1, 1'b1);
        add(32'h008, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, NOP,      32'h1000, 1'b1, 1'b1);
        add(32'h00C, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, m(2),     32'h008,  1'b1, 1'b0);

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        #1;
        row = -1;
        chk("rst_inst", id_inst, NOP);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_fault", 32'(id_fault), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            pc_addr = vecs[i].pc;
            pc_en = vecs[i].en;
            load_hazard = vecs[i].lh;
            pc_write_flag = vecs[i].wf;
            pc_write_addr = vecs[i].wa;
            #1;
            want_idx = vecs[i].pc >> 2;
            chk("ram_en", 32'(ram_en), 32'(vecs[i].x_ram_en));
            chk("ram_addr", 32'(ram_addr), want_idx & 32'h3FF);
            chk("id_inst", id_inst, vecs[i].x_inst);
            chk("id_pc", id_pc, vecs[i].x_pc);
            chk("id_valid", 32'(id_valid), 32'(vecs[i].x_valid));
            chk("id_fault", 32'(id_fault), 32'(vecs[i].x_fault));
            @(negedge clk);
        end

        // Enter a stall, then assert reset in the middle of it.
        row = 100;
        pc_addr = 32'h10;
        load_hazard = 1'b1;
        pc_write_flag = 1'b0;
        #1;
        chk("stall_ram_en", 32'(ram_en), 32'h0);
        @(negedge clk);
        #1;
        chk("stall_pc", id_pc, 32'h00C);
        chk("stall_inst", id_inst, m(3));
        chk("stall_valid", 32'(id_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(id_valid), 32'h0);
        chk("midrst_pc", id_pc, 32'h0);
        chk("midrst_inst", id_inst, NOP);
        chk("midrst_fault", 32'(id_fault), 32'h0);

        // Restart from reset: boot bubble, then M[0].
        @(negedge clk);
        row = 101;
        rst = 1'b0;
        load_hazard = 1'b0;
        pc_addr = 32'h0;
        pc_en = 1'b1;
        #1;
        chk("reboot_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        pc_addr = 32'h4;
        #1;
        chk("reboot_inst", id_inst, m(0));
        chk("reboot_pc", id_pc, 32'h0);
        chk("reboot_v", 32'(id_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
